// File: rtl/clock_display_scan.sv
// Scans a snapshotted 12-hour BCD time onto a 3-digit multiplexed 7-segment display.
// Pages between hours+AM/PM, minutes and seconds, and flags malformed BCD.
module clock_display_scan #(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned BLANK_CYC  = 2000,
  parameter int unsigned PAGE_SCANS = 667
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic [7:0] ss,
  input  logic       pm,
  input  logic [1:0] mode,
  output logic [7:0] seg_n,
  output logic [2:0] an_n,
  output logic [1:0] page,
  output logic       bcd_err
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam int unsigned PW = $clog2(PAGE_SCANS + 1);

  typedef enum logic {BLANK, DRIVE} slot_t;

  slot_t         slot_q, slot_d;
  logic [CW-1:0] cnt, cnt_next;
  logic [1:0]    dig;
  logic [PW-1:0] scan_cnt;
  logic [7:0]    snap_hh, snap_mm, snap_ss;
  logic          snap_pm;
  logic [1:0]    snap_mode;
  logic          snap_now;
  logic          slot_wrap;
  logic          new_bad;
  logic [7:0]    seg_d;
  logic [2:0]    an_d;

  function automatic logic [7:0] digit_code(input logic [3:0] n);
    case (n)
      4'd0:    digit_code = 8'hC0;
      4'd1:    digit_code = 8'hF9;
      4'd2:    digit_code = 8'hA4;
      4'd3:    digit_code = 8'hB0;
      4'd4:    digit_code = 8'h99;
      4'd5:    digit_code = 8'h92;
      4'd6:    digit_code = 8'h82;
      4'd7:    digit_code = 8'hF8;
      4'd8:    digit_code = 8'h80;
      4'd9:    digit_code = 8'h90;
      default: digit_code = 8'h86;
    endcase
  endfunction

  assign slot_wrap = (cnt == CW'(SCAN_DIV - 1));
  assign cnt_next  = slot_wrap ? '0 : cnt + CW'(1);
  assign snap_now  = (cnt == '0) && (dig == 2'd2);
  assign new_bad   = (hh[7:4] > 4'd9) || (hh[3:0] > 4'd9) || (mm[7:4] > 4'd9) ||
                     (mm[3:0] > 4'd9) || (ss[7:4] > 4'd9) || (ss[3:0] > 4'd9);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      dig <= 2'd2;
    end else begin
      cnt <= cnt_next;
      if (slot_wrap) dig <= (dig == 2'd0) ? 2'd2 : dig - 2'd1;
    end
  end

  // Snapshot and page stepping share one edge so a page never shows a torn time.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_hh   <= '0;
      snap_mm   <= '0;
      snap_ss   <= '0;
      snap_pm   <= 1'b0;
      snap_mode <= 2'b00;
      scan_cnt  <= '0;
      page      <= 2'd0;
      bcd_err   <= 1'b0;
    end else if (snap_now) begin
      snap_hh   <= hh;
      snap_mm   <= mm;
      snap_ss   <= ss;
      snap_pm   <= pm;
      snap_mode <= mode;
      if (new_bad) bcd_err <= 1'b1;
      if (mode == 2'b00) begin
        if (snap_mode != 2'b00) begin
          scan_cnt <= '0;
        end else if (scan_cnt == PW'(PAGE_SCANS - 1)) begin
          scan_cnt <= '0;
          page     <= (page == 2'd2) ? 2'd0 : page + 2'd1;
        end else begin
          scan_cnt <= scan_cnt + PW'(1);
        end
      end else begin
        scan_cnt <= '0;
        page     <= mode - 2'd1;
      end
    end
  end

  // Slot state tracks the cnt value it will sit beside, so it lines up with cnt.
  always_ff @(posedge clk) begin
    if (reset) slot_q <= BLANK;
    else       slot_q <= slot_d;
  end

  always_comb begin
    slot_d = (cnt_next < CW'(BLANK_CYC)) ? BLANK : DRIVE;
  end

  always_comb begin
    seg_d = 8'hFF;
    an_d  = 3'b111;
    if (slot_q == DRIVE) begin
      an_d = ~(3'b001 << dig);
      case (page)
        2'd0: begin
          case (dig)
            2'd2:    seg_d = (snap_hh[7:4] == 4'd0) ? 8'hFF : digit_code(snap_hh[7:4]);
            2'd1:    seg_d = digit_code(snap_hh[3:0]);
            default: seg_d = snap_pm ? 8'h8C : 8'h88;
          endcase
        end
        2'd1: begin
          case (dig)
            2'd2:    seg_d = 8'hBF;
            2'd1:    seg_d = digit_code(snap_mm[7:4]);
            default: seg_d = digit_code(snap_mm[3:0]);
          endcase
        end
        2'd2: begin
          case (dig)
            2'd2:    seg_d = 8'hF7;
            2'd1:    seg_d = digit_code(snap_ss[7:4]);
            default: seg_d = digit_code(snap_ss[3:0]);
          endcase
        end
        default: seg_d = 8'hFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_n <= '1;
      an_n  <= '1;
    end else begin
      seg_n <= seg_d;
      an_n  <= an_d;
    end
  end

endmodule

// File: tb/tb_clock_display_scan.sv
// Bench for clock_display_scan: directed and random time/mode stimulus compared every
// cycle against a cycle-index reference model of the scan, snapshot and paging rules.
module tb_clock_display_scan;

  localparam int unsigned SD  = 8;
  localparam int unsigned BC  = 2;
  localparam int unsigned PS  = 2;
  localparam int unsigned PER = 3 * SD;

  logic       clk;
  logic       reset;
  logic [7:0] hh, mm, ss;
  logic       pm;
  logic [1:0] mode;
  logic [7:0] seg_n;
  logic [2:0] an_n;
  logic [1:0] page;
  logic       bcd_err;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  // reference model state
  int unsigned k;
  logic [7:0]  m_seg;
  logic [2:0]  m_an;
  int unsigned m_page, m_scans;
  logic        m_err;
  logic [7:0]  m_hh, m_mm, m_ss;
  logic        m_pm;
  logic [1:0]  m_mode;
  logic [7:0]  lut [10];

  clock_display_scan #(
    .SCAN_DIV  (SD),
    .BLANK_CYC (BC),
    .PAGE_SCANS(PS)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .hh     (hh),
    .mm     (mm),
    .ss     (ss),
    .pm     (pm),
    .mode   (mode),
    .seg_n  (seg_n),
    .an_n   (an_n),
    .page   (page),
    .bcd_err(bcd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] nib_glyph(input logic [3:0] n);
    if (n > 4'd9) return 8'h86;
    return lut[n];
  endfunction

  function automatic logic [7:0] model_glyph(input int unsigned p, input int unsigned d);
    if (p == 0) begin
      if (d == 2) return (m_hh[7:4] == 4'd0) ? 8'hFF : nib_glyph(m_hh[7:4]);
      if (d == 1) return nib_glyph(m_hh[3:0]);
      return m_pm ? 8'h8C : 8'h88;
    end else if (p == 1) begin
      if (d == 2) return 8'hBF;
      if (d == 1) return nib_glyph(m_mm[7:4]);
      return nib_glyph(m_mm[3:0]);
    end
    if (d == 2) return 8'hF7;
    if (d == 1) return nib_glyph(m_ss[7:4]);
    return nib_glyph(m_ss[3:0]);
  endfunction

  function automatic logic [7:0] to_bcd(input int unsigned v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic logic any_bad(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    return (a[7:4] > 9) || (a[3:0] > 9) || (b[7:4] > 9) || (b[3:0] > 9) ||
           (c[7:4] > 9) || (c[3:0] > 9);
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, got, exp);
    end
  endtask

  // Advance one clock: update model from the inputs the DUT will sample, then compare.
  task automatic tick();
    int unsigned pos, cnt, dig;
    if (reset) begin
      k = 0; m_seg = 8'hFF; m_an = 3'b111; m_page = 0; m_scans = 0; m_err = 1'b0;
      m_hh = '0; m_mm = '0; m_ss = '0; m_pm = 1'b0; m_mode = 2'b00;
    end else begin
      pos = k % PER;
      cnt = pos % SD;
      dig = 2 - pos / SD;
      if (cnt < BC) begin
        m_seg = 8'hFF;
        m_an  = 3'b111;
      end else begin
        m_an      = 3'b111;
        m_an[dig] = 1'b0;
        m_seg     = model_glyph(m_page, dig);
      end
      if (pos == 0) begin
        if (any_bad(hh, mm, ss)) m_err = 1'b1;
        if (mode == 2'b00) begin
          if (m_mode != 2'b00) m_scans = 0;
          else begin
            m_scans++;
            if (m_scans == PS) begin
              m_scans = 0;
              m_page  = (m_page + 1) % 3;
            end
          end
        end else begin
          m_page = int'(mode) - 1;
        end
        m_hh = hh; m_mm = mm; m_ss = ss; m_pm = pm; m_mode = mode;
      end
      k++;
    end
    @(posedge clk);
    #1;
    check("seg_n", seg_n, m_seg);
    check("an_n", {5'b0, an_n}, {5'b0, m_an});
    check("page", {6'b0, page}, 8'(m_page));
    check("bcd_err", {7'b0, bcd_err}, {7'b0, m_err});
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic rand_time();
    hh = to_bcd($urandom_range(1, 12));
    mm = to_bcd($urandom_range(0, 59));
    ss = to_bcd($urandom_range(0, 59));
    pm = 1'($urandom_range(0, 1));
  endtask

  initial begin
    lut = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    reset = 1'b1; hh = 8'h12; mm = 8'h34; ss = 8'h56; pm = 1'b1; mode = 2'b01;
    k = 0;

    // reset held, then released showing 12 .. P on the hours page
    run(5);
    check("rst_seg", seg_n, 8'hFF);
    check("rst_an", {5'b0, an_n}, 8'h07);
    reset = 1'b0;
    run(2 * PER);

    // leading-zero blanking and AM
    hh = 8'h07; pm = 1'b0;
    run(2 * PER);

    // auto paging with minutes and seconds pages
    mode = 2'b00; mm = 8'h05; ss = 8'h09;
    run(8 * PER);

    // mid-scan change must wait for the next snapshot
    mode = 2'b11; ss = 8'h00;
    run(PER + 10);
    ss = 8'h01;
    run(2 * PER);

    // random valid times, occasional mode changes, changes at arbitrary cycles
    for (int unsigned i = 0; i < 700; i++) begin
      if ($urandom_range(0, 15) == 0) rand_time();
      if ($urandom_range(0, 60) == 0) mode = 2'($urandom_range(0, 3));
      tick();
    end

    // malformed minutes: 'E' and sticky error
    mode = 2'b10; mm = 8'h3A;
    run(2 * PER);
    mm = 8'h42;
    run(2 * PER);

    // random stimulus including invalid nibbles and range violations
    for (int unsigned i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        hh = 8'($urandom_range(0, 255));
        mm = 8'($urandom_range(0, 255));
        ss = 8'($urandom_range(0, 255));
        pm = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 60) == 0) mode = 2'($urandom_range(0, 3));
      tick();
    end

    // reset in the middle of a driven slot, then restart
    mode = 2'b00;
    for (int unsigned i = 0; i < SD && (k % SD) < 4; i++) tick();
    reset = 1'b1;
    tick();
    check("midrst_an", {5'b0, an_n}, 8'h07);
    check("midrst_seg", seg_n, 8'hFF);
    check("midrst_page", {6'b0, page}, 8'h00);
    reset = 1'b0; hh = 8'h11; mm = 8'h22; ss = 8'h33;
    run(10 * PER);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
